// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter with a one-word holding register,
// a single-cycle delivery strobe and a sticky overflow flag.
module deserializer #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_data,
  input  logic             ser_strobe,
  input  logic             ser_clear,
  output logic [WIDTH-1:0] par_data,
  input  logic             par_ready,
  output logic             par_strobe,
  output logic             overflow,
  output logic             is_empty
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_STROBE  = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t                 state_r;
  logic [WIDTH-1:0]       shifter_r;
  logic [WIDTH-1:0]       shifter_next_s;
  logic [WIDTH-1:0]       word_s;
  logic [COUNT_WIDTH-1:0] bit_count_r;
  logic [COUNT_WIDTH-1:0] bit_count_next_s;
  logic                   complete_s;
  logic                   count_zero_next_s;

  // Shift datapath next-state; a clear discards any coincident bit.
  always_comb begin
    word_s     = {shifter_r[WIDTH-2:0], ser_data};
    complete_s = ser_strobe && !ser_clear &&
                 (bit_count_r == COUNT_WIDTH'(WIDTH - 1));
    if (ser_clear) begin
      shifter_next_s   = '0;
      bit_count_next_s = '0;
    end else if (ser_strobe) begin
      shifter_next_s   = word_s;
      bit_count_next_s = complete_s ? COUNT_WIDTH'(0)
                                    : bit_count_r + COUNT_WIDTH'(1);
    end else begin
      shifter_next_s   = shifter_r;
      bit_count_next_s = bit_count_r;
    end
    count_zero_next_s = (bit_count_next_s == COUNT_WIDTH'(0));
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter_r   <= '0;
      bit_count_r <= '0;
    end else begin
      shifter_r   <= shifter_next_s;
      bit_count_r <= bit_count_next_s;
    end
  end

  // Output FSM with registered strobe, data, overflow and empty flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_EMPTY;
      par_data   <= '0;
      par_strobe <= 1'b0;
      overflow   <= 1'b0;
      is_empty   <= 1'b1;
    end else begin
      case (state_r)
        S_EMPTY: begin
          if (complete_s) begin
            par_data   <= word_s;
            par_strobe <= par_ready;
            state_r    <= par_ready ? S_STROBE : S_PENDING;
            is_empty   <= 1'b0;
          end else begin
            par_strobe <= 1'b0;
            state_r    <= S_EMPTY;
            is_empty   <= count_zero_next_s;
          end
        end
        // par_ready is deliberately ignored here so strobes never abut.
        S_STROBE: begin
          par_strobe <= 1'b0;
          if (complete_s) begin
            par_data <= word_s;
            state_r  <= S_PENDING;
            is_empty <= 1'b0;
          end else begin
            state_r  <= S_EMPTY;
            is_empty <= count_zero_next_s;
          end
        end
        S_PENDING: begin
          if (complete_s) begin
            overflow <= 1'b1;
          end else begin
            overflow <= overflow;
          end
          par_strobe <= par_ready;
          state_r    <= par_ready ? S_STROBE : S_PENDING;
          is_empty   <= 1'b0;
        end
        default: begin
          par_strobe <= 1'b0;
          state_r    <= S_EMPTY;
          is_empty   <= count_zero_next_s;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer.
module tb_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_data = 1'b0;
  logic       ser_strobe = 1'b0;
  logic       ser_clear = 1'b0;
  logic [7:0] par_data;
  logic       par_ready = 1'b0;
  logic       par_strobe;
  logic       overflow;
  logic       is_empty;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int double_cnt = 0;
  logic prev_strobe = 1'b0;

  deserializer #(.WIDTH(8), .COUNT_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_data   (ser_data),
    .ser_strobe (ser_strobe),
    .ser_clear  (ser_clear),
    .par_data   (par_data),
    .par_ready  (par_ready),
    .par_strobe (par_strobe),
    .overflow   (overflow),
    .is_empty   (is_empty)
  );

  always #5 clk = ~clk;

  // Count delivered words and flag any back-to-back strobes.
  always @(negedge clk) begin
    if (par_strobe) begin
      pulse_cnt = pulse_cnt + 1;
      if (prev_strobe) double_cnt = double_cnt + 1;
    end
    prev_strobe = par_strobe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_data   = b;
    ser_strobe = 1'b1;
    tick();
    ser_strobe = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (par_data !== 8'h00 || par_strobe !== 1'b0 || overflow !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: data=%h strobe=%b ovf=%b empty=%b, expected 00 0 0 1",
               par_data, par_strobe, overflow, is_empty);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (par_strobe !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_idle: strobe=%b empty=%b, expected 0 1", par_strobe, is_empty);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    par_ready = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i]);
      if (i == 6) begin
        vectors++;
        if (par_strobe !== 1'b0 || is_empty !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_bit7: strobe=%b empty=%b, expected 0 0", par_strobe, is_empty);
        end
      end
    end
    vectors++;
    if (par_strobe !== 1'b1 || par_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_word: strobe=%b data=%h, expected 1 a5", par_strobe, par_data);
    end
    tick();
    vectors++;
    if (par_strobe !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after: strobe=%b empty=%b, expected 0 1", par_strobe, is_empty);
    end
    tick();
    vectors++;
    if (pulse_cnt !== 1) begin
      miscompares++;
      $display("FAIL basic_pulses: got %0d, expected 1", pulse_cnt);
    end
  endtask

  task automatic test_stall_gaps();
    logic [7:0] w;
    int gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 0};
    w = 8'h3C;
    par_ready = 1'b0;
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i]);
      repeat (gaps[i]) tick();
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (par_strobe !== 1'b0 || is_empty !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: strobe=%b empty=%b, expected 0 0", par_strobe, is_empty);
      end
    end
    tick();
    par_ready = 1'b1;
    tick();
    vectors++;
    if (par_strobe !== 1'b1 || par_data !== 8'h3C || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: strobe=%b data=%h ovf=%b, expected 1 3c 0",
               par_strobe, par_data, overflow);
    end
    tick();
    vectors++;
    if (par_strobe !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_after: strobe=%b empty=%b, expected 0 1", par_strobe, is_empty);
    end
    tick();
    vectors++;
    if (pulse_cnt !== 1) begin
      miscompares++;
      $display("FAIL stall_pulses: got %0d, expected 1", pulse_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic        exp_s;
    w = 16'hFF00;
    par_ready = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[15-i]);
      exp_s = (i == 7 || i == 15);
      vectors++;
      if (par_strobe !== exp_s) begin
        miscompares++;
        $display("FAIL b2b_strobe[%0d]: got %b, expected %b", i, par_strobe, exp_s);
      end
      if (i == 7) begin
        vectors++;
        if (par_data !== 8'hFF) begin
          miscompares++;
          $display("FAIL b2b_word0: got %h, expected ff", par_data);
        end
      end
      if (i == 15) begin
        vectors++;
        if (par_data !== 8'h00) begin
          miscompares++;
          $display("FAIL b2b_word1: got %h, expected 00", par_data);
        end
      end
    end
    tick();
    tick();
    vectors++;
    if (pulse_cnt !== 2 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d empty=%b, expected 2 1", pulse_cnt, is_empty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    w = 16'h1122;
    par_ready = 1'b0;
    pulse_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[15-i]);
      if (i == 14) begin
        vectors++;
        if (overflow !== 1'b0 || par_data !== 8'h11) begin
          miscompares++;
          $display("FAIL ovf_before: ovf=%b data=%h, expected 0 11", overflow, par_data);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b1 || par_data !== 8'h11 || par_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_set: ovf=%b data=%h strobe=%b, expected 1 11 0",
               overflow, par_data, par_strobe);
    end
    par_ready = 1'b1;
    tick();
    vectors++;
    if (par_strobe !== 1'b1 || par_data !== 8'h11) begin
      miscompares++;
      $display("FAIL ovf_release: strobe=%b data=%h, expected 1 11", par_strobe, par_data);
    end
    tick();
    vectors++;
    if (par_strobe !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_after: strobe=%b empty=%b, expected 0 1", par_strobe, is_empty);
    end
    repeat (3) tick();
    vectors++;
    if (pulse_cnt !== 1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: pulses=%0d ovf=%b, expected 1 1", pulse_cnt, overflow);
    end
  endtask

  task automatic test_clear();
    logic [7:0] w;
    w = 8'h81;
    par_ready = 1'b1;
    pulse_cnt = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ser_clear  = 1'b1;
    ser_strobe = 1'b1;
    ser_data   = 1'b1;
    tick();
    ser_clear  = 1'b0;
    ser_strobe = 1'b0;
    vectors++;
    if (is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_empty: got %b, expected 1", is_empty);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i]);
      if (i == 6) begin
        vectors++;
        if (par_strobe !== 1'b0) begin
          miscompares++;
          $display("FAIL clear_early: strobe=%b, expected 0", par_strobe);
        end
      end
    end
    vectors++;
    if (par_strobe !== 1'b1 || par_data !== 8'h81) begin
      miscompares++;
      $display("FAIL clear_word: strobe=%b data=%h, expected 1 81", par_strobe, par_data);
    end
    tick();
    tick();
    vectors++;
    if (pulse_cnt !== 1) begin
      miscompares++;
      $display("FAIL clear_pulses: got %0d, expected 1", pulse_cnt);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    w = 8'h77;
    par_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(w[7-i]);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (par_data !== 8'h00 || par_strobe !== 1'b0 || overflow !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_values: data=%h strobe=%b ovf=%b empty=%b, expected 00 0 0 1",
               par_data, par_strobe, overflow, is_empty);
    end
    pulse_cnt = 0;
    par_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (pulse_cnt !== 0) begin
      miscompares++;
      $display("FAIL midreset_nostrobe: pulses=%0d, expected 0", pulse_cnt);
    end
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i]);
      if (i == 6) begin
        vectors++;
        if (par_strobe !== 1'b0) begin
          miscompares++;
          $display("FAIL midreset_early: strobe=%b, expected 0", par_strobe);
        end
      end
    end
    vectors++;
    if (par_strobe !== 1'b1 || par_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL midreset_word: strobe=%b data=%h, expected 1 5a", par_strobe, par_data);
    end
    tick();
    tick();
    vectors++;
    if (pulse_cnt !== 1 || overflow !== 1'b0 || is_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_after: pulses=%0d ovf=%b empty=%b, expected 1 0 1",
               pulse_cnt, overflow, is_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_gaps();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_reset_midword();
    vectors++;
    if (double_cnt !== 0) begin
      miscompares++;
      $display("FAIL strobe_spacing: %0d consecutive strobes, expected 0", double_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
